// File: rtl/spi_adc_responder.sv
// spi_adc_responder: SPI responder emulating a 12-bit serial ADC; define SPI_RESP_RX_EN to capture MOSI words.
module spi_adc_responder #(
  parameter int FRAME_BITS = 16,
  parameter int DATA_BITS  = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  sck,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_BITS-1:0]  s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_done,
  output logic                  frame_abort,
  output logic                  underrun
);
  localparam int PAD = FRAME_BITS - DATA_BITS;
  localparam int CW  = $clog2(FRAME_BITS + 1);
  typedef enum logic [1:0] {IDLE, ACTIVE, WAIT_CS_HIGH} state_t;
  state_t state, state_n;
  logic [1:0] cs_s, sck_s, mosi_s, warm;
  logic cs_d, sck_d, cs_fall, cs_rise, sck_rise, sck_fall;
  logic [FRAME_BITS-1:0] tx;
  logic [CW-1:0] cnt;
  logic [DATA_BITS-1:0] hold_data, last;
  logic hold_full, start, abort, done, accept;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_s     <= 2'b11;
      sck_s    <= '0;
      mosi_s   <= '0;
      cs_d     <= 1'b1;
      sck_d    <= 1'b0;
      cs_fall  <= 1'b0;
      cs_rise  <= 1'b0;
      sck_rise <= 1'b0;
      sck_fall <= 1'b0;
      warm     <= '0;
    end else begin
      cs_s     <= {cs_s[0], cs};
      sck_s    <= {sck_s[0], sck};
      mosi_s   <= {mosi_s[0], mosi};
      cs_d     <= cs_s[1];
      sck_d    <= sck_s[1];
      cs_fall  <= (warm == 2'd3) && cs_d && !cs_s[1];
      cs_rise  <= !cs_d && cs_s[1];
      sck_rise <= !sck_d && sck_s[1];
      sck_fall <= sck_d && !sck_s[1];
      warm     <= warm + {1'b0, warm != 2'd3};
    end
  end
  // warm==2 is the one cycle where the synchronizer first shows the real CS level after reset
  always_comb begin
    start   = (state == IDLE) && cs_fall;
    abort   = (state == ACTIVE) && cs_rise;
    done    = (state == ACTIVE) && !cs_rise && sck_rise && (cnt == CW'(FRAME_BITS - 1));
    accept  = s_valid && !hold_full;
    state_n = (state == IDLE && warm == 2'd2 && !cs_s[1]) ? WAIT_CS_HIGH :
              start ? ACTIVE :
              abort ? IDLE :
              done  ? WAIT_CS_HIGH :
              (state == WAIT_CS_HIGH && cs_s[1]) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx          <= '0;
      cnt         <= '0;
      hold_full   <= 1'b0;
      hold_data   <= '0;
      last        <= '0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_done  <= done;
      frame_abort <= abort;
      underrun    <= start && !hold_full;
      hold_full   <= accept || (hold_full && !start);
      if (accept) hold_data <= s_data;
      if (start) begin
        tx  <= {{PAD{1'b0}}, hold_full ? hold_data : last};
        cnt <= '0;
        if (hold_full) last <= hold_data;
      end else if (state == ACTIVE) begin
        if (sck_fall) tx <= tx << 1;
        if (sck_rise) cnt <= cnt + CW'(1);
      end
    end
  end
  assign miso    = (state == ACTIVE) && tx[FRAME_BITS-1];
  assign miso_oe = state != IDLE;
  assign s_ready = !hold_full;
`ifdef SPI_RESP_RX_EN
  logic [FRAME_BITS-1:0] rx_sr;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sr    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= done;
      if (state == ACTIVE && sck_rise) rx_sr <= {rx_sr[FRAME_BITS-2:0], mosi_s[1]};
      if (done) rx_data <= {rx_sr[FRAME_BITS-2:0], mosi_s[1]};
    end
  end
`else
  logic unused_mosi;
  assign unused_mosi = ^mosi_s;
  assign rx_data     = '0;
  assign rx_valid    = 1'b0;
`endif
endmodule

// File: tb/tb_spi_adc_responder.sv
// tb_spi_adc_responder: table-driven SPI master bench with MISO and MOSI-word scoreboards.
module tb_spi_adc_responder;
`ifdef SPI_RESP_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif
  logic clk = 0, reset = 1, cs = 1, sck = 0, mosi = 0, s_valid = 0;
  logic [11:0] s_data = '0;
  logic miso, miso_oe, s_ready, rx_valid, frame_done, frame_abort, underrun;
  logic [15:0] rx_data;
  int n_checks = 0, n_fail = 0, n_done = 0, n_abort = 0, n_under = 0;
  logic [15:0] miso_q[$], rx_q[$];
  logic [15:0] last_rx = '0;

  spi_adc_responder dut (
    .clk(clk), .reset(reset), .cs(cs), .sck(sck), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_done(frame_done), .frame_abort(frame_abort), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (frame_done) n_done++;
    if (frame_abort) n_abort++;
    if (underrun) n_under++;
    if (frame_done || rx_valid) check("rx_valid_vs_done", {31'b0, rx_valid}, {31'b0, RX_EN & frame_done});
    if (frame_done) begin
      if (rx_q.size() == 0) check("rx_q_nonempty", 0, 1);
      else begin
        logic [15:0] w;
        w = rx_q.pop_front();
        check("rx_data", {16'b0, rx_data}, RX_EN ? {16'b0, w} : 32'b0);
      end
    end
  end

  task automatic load(input logic [11:0] d);
    for (int i = 0; i < 50 && !s_ready; i++) @(negedge clk);
    if (!s_ready) check("s_ready_timeout", {31'b0, s_ready}, 1);
    @(negedge clk);
    s_valid = 1;
    s_data = d;
    @(negedge clk);
    s_valid = 0;
  endtask

  task automatic spi_frame(input logic [15:0] mw, input int nbits, input int extra, input bit inject,
                           input logic [11:0] inj, output logic [15:0] got, output logic extra_hi);
    got = '0;
    extra_hi = 0;
    @(negedge clk);
    cs = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (inject && k == 3) begin
        s_valid = 1;
        s_data = inj;
      end
      if (k == 4) begin
        check("oe_at_start", {31'b0, miso_oe}, 1);
        if (inject) begin
          s_valid = 0;
          check("underrun_same_cycle", {31'b0, underrun}, 1);
        end
      end
    end
    for (int i = 0; i < nbits; i++) begin
      mosi = mw[15-i];
      repeat (5) @(negedge clk);
      got = {got[14:0], miso};
      sck = 1;
      repeat (5) @(negedge clk);
      sck = 0;
    end
    for (int i = 0; i < extra; i++) begin
      repeat (5) @(negedge clk);
      extra_hi |= miso;
      sck = 1;
      repeat (5) @(negedge clk);
      extra_hi |= miso;
      sck = 0;
    end
    repeat (4) @(negedge clk);
    cs = 1;
    mosi = 0;
    repeat (8) @(negedge clk);
  endtask

  typedef struct {
    logic        load;
    logic [11:0] sample;
    logic [15:0] mw;
    int          nbits;
    logic [15:0] exp_miso;
    int          exp_under;
    int          exp_done;
    int          exp_abort;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    int b_done, b_abort, b_under;
    logic [15:0] got, exp_w;
    logic xh;
    if (v.load) load(v.sample);
    b_done = n_done;
    b_abort = n_abort;
    b_under = n_under;
    miso_q.push_back(v.exp_miso >> (16 - v.nbits));
    if (v.nbits == 16) rx_q.push_back(v.mw);
    spi_frame(v.mw, v.nbits, 0, 0, '0, got, xh);
    exp_w = miso_q.pop_front();
    check({tag, "_miso"}, {16'b0, got}, {16'b0, exp_w});
    check({tag, "_done"}, n_done - b_done, v.exp_done);
    check({tag, "_abort"}, n_abort - b_abort, v.exp_abort);
    check({tag, "_underrun"}, n_under - b_under, v.exp_under);
    check({tag, "_ready_oe"}, {30'b0, s_ready, miso_oe}, 32'b10);
    if (v.nbits == 16) last_rx = v.mw;
    else check({tag, "_rx_kept"}, {16'b0, rx_data}, RX_EN ? {16'b0, last_rx} : 32'b0);
  endtask

  initial begin
    vec_t vt[7];
    logic [15:0] got;
    logic xh;
    int b_done, b_under;
    logic miso_or;
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[7];
    logic [15:0] got;
    logic xh, miso_or;
    int b_done, b_under;
    vt[0] = '{1'b1, 12'hA5C, 16'hC3A1, 16, 16'h0A5C, 0, 1, 0};
    vt[1] = '{1'b0, 12'h000, 16'h1234, 16, 16'h0A5C, 1, 1, 0};
    vt[2] = '{1'b1, 12'h3F0, 16'hFFFF, 7,  16'h03F0, 0, 0, 1};
    vt[3] = '{1'b1, 12'h7E1, 16'h8001, 16, 16'h07E1, 0, 1, 0};
    vt[4] = '{1'b1, 12'hFFF, 16'h0000, 16, 16'h0FFF, 0, 1, 0};
    vt[5] = '{1'b1, 12'h000, 16'hFFFF, 16, 16'h0000, 0, 1, 0};
    vt[6] = '{1'b1, 12'h800, 16'h5AA5, 16, 16'h0800, 0, 1, 0};
    repeat (3) @(negedge clk);
    check("reset_outputs", {25'b0, miso, miso_oe, s_ready, rx_valid, frame_done, frame_abort, underrun}, 32'b0010000);
    check("reset_rx_data", {16'b0, rx_data}, 0);
    reset = 0;
    repeat (5) @(negedge clk);
    for (int v = 0; v < 7; v++) run_vec(vt[v], $sformatf("vec%0d", v));

    // sample offered in the very cycle the frame starts: old sample goes out, new one next frame
    b_under = n_under;
    miso_q.push_back(16'h0800);
    rx_q.push_back(16'h0F0F);
    spi_frame(16'h0F0F, 16, 0, 1, 12'h5A5, got, xh);
    check("inject_miso", {16'b0, got}, {16'b0, miso_q.pop_front()});
    check("inject_underrun", n_under - b_under, 1);
    run_vec('{1'b0, 12'h000, 16'hF0F0, 16, 16'h05A5, 0, 1, 0}, "after_inject");

    // reset in the middle of a frame with CS held low
    load(12'h321);
    @(negedge clk);
    cs = 0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sck = 1;
      repeat (5) @(negedge clk);
      sck = 0;
      repeat (5) @(negedge clk);
    end
    #1 reset = 1;
    #1;
    check("midframe_reset_outputs", {25'b0, miso, miso_oe, s_ready, rx_valid, frame_done, frame_abort, underrun}, 32'b0010000);
    check("midframe_reset_rx", {16'b0, rx_data}, 0);
    last_rx = '0;
    repeat (3) @(negedge clk);
    reset = 0;
    repeat (10) @(negedge clk);
    b_done = n_done;
    b_under = n_under;
    miso_or = 0;
    for (int i = 0; i < 16; i++) begin
      mosi = i[0];
      repeat (5) @(negedge clk);
      miso_or |= miso;
      sck = 1;
      repeat (5) @(negedge clk);
      sck = 0;
    end
    repeat (6) @(negedge clk);
    check("no_frame_after_reset_done", n_done - b_done, 0);
    check("no_frame_after_reset_underrun", n_under - b_under, 0);
    check("no_frame_after_reset_miso", {31'b0, miso_or}, 0);
    cs = 1;
    mosi = 0;
    repeat (10) @(negedge clk);
    load(12'h321);
    b_done = n_done;
    b_under = n_under;
    miso_q.push_back(16'h0321);
    rx_q.push_back(16'hA55A);
    spi_frame(16'hA55A, 16, 20, 0, '0, got, xh);
    check("post_reset_miso", {16'b0, got}, {16'b0, miso_q.pop_front()});
    check("post_reset_done", n_done - b_done, 1);
    check("post_reset_underrun", n_under - b_under, 0);
    check("extra_sck_miso_low", {31'b0, xh}, 0);
    check("rx_q_drained", rx_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_adc_responder.md
# spi_adc_responder

SPI peripheral (responder) that emulates the 12-bit serial ADC read by the team's SPI master state machine. It watches the master's CS, SCK and MOSI lines, shifts a 16-bit frame (4 leading zeros followed by a 12-bit sample, MSB first) out on MISO, and optionally captures the master's MOSI word. It sits on the far end of the SPI link and stands in for the real ADC in loopback tests, pin-mux bring-up and self-test builds.

## Interface
Parameters:
- `FRAME_BITS`, default 16: SCK rising edges per frame.
- `DATA_BITS`, default 12: sample width, right-aligned in the frame; leading `FRAME_BITS-DATA_BITS` bits are 0.

Ports:
- `clk`  input  1  system clock; the only clock.
- `reset`  input  1  asynchronous, active-high reset.
- `cs`  input  1  chip select from the master, active low, asynchronous to `clk`.
- `sck`  input  1  serial clock from the master (CPOL=0, CPHA=0), asynchronous to `clk`.
- `mosi`  input  1  master data out, asynchronous to `clk`.
- `miso`  output  1  responder data out.
- `miso_oe`  output  1  1 while a frame is active; board logic uses it as the MISO tri-state enable.
- `s_data`  input  DATA_BITS  next sample to transmit.
- `s_valid`  input  1  `s_data` is valid.
- `s_ready`  output  1  holding register is empty and can accept a sample.
- `rx_data`  output  FRAME_BITS  last complete MOSI word.
- `rx_valid`  output  1  one-cycle pulse when `rx_data` updates.
- `frame_done`  output  1  one-cycle pulse after the last SCK rising edge of a full frame.
- `frame_abort`  output  1  one-cycle pulse when CS rises before the frame is complete.
- `underrun`  output  1  one-cycle pulse when a frame starts with no new sample waiting.

## Operation
- `cs`, `sck` and `mosi` each pass through a 2-flop synchronizer. Reset values are cs=1, sck=0, mosi=0. Edges are detected on the synchronized values.
- States:
  - IDLE: wait for a CS falling edge.
  - ACTIVE: shift bits.
  - WAIT_CS_HIGH: frame complete or blocked; wait for CS to return high.
- IDLE to ACTIVE on a CS falling edge:
  - If the holding register is full, load `{zeros, holding}` into the shift register and empty the holding register.
  - If it is empty, reload the last transmitted sample and pulse `underrun`.
  - Clear the bit counter and set `miso_oe`=1. `miso` shows the frame MSB.
- ACTIVE:
  - On each SCK rising edge: sample `mosi` into the rx shift register and increment the bit counter.
  - On each SCK falling edge: shift the tx register left and present the next bit on `miso`.
  - On the rising edge that brings the counter to FRAME_BITS: pulse `frame_done`, update `rx_data` and pulse `rx_valid` in the same cycle, then go to WAIT_CS_HIGH.
  - CS rising edge before FRAME_BITS rising edges: pulse `frame_abort`, leave `rx_data` unchanged, go to IDLE. The sample already consumed is not restored.
- WAIT_CS_HIGH:
  - Extra SCK edges are ignored and `miso` is held at 0.
  - CS high moves the block to IDLE with `miso_oe`=0.
- Holding register (one entry):
  - `s_ready` = holding empty. A sample is accepted when `s_valid && s_ready`.
  - If an accept and a frame start happen in the same cycle, the frame sees the register as empty (underrun, old sample resent) and the new sample is stored for the next frame.
- `miso` is 0 whenever `miso_oe` is 0.
- Reset values: `miso`=0, `miso_oe`=0, `s_ready`=1, `rx_data`=0, `rx_valid`=0, `frame_done`=0, `frame_abort`=0, `underrun`=0, last-sample register=0, state=IDLE.
- Reset mid-frame returns to IDLE. If CS is still low after reset, no frame starts until CS has been seen high and then falls again; the block enters WAIT_CS_HIGH when the synchronized CS reads 0 out of reset.

## Timing
- Input to internal event latency: 3 `clk` cycles (2 synchronizer stages plus 1 edge-detect register).
- `miso` changes 4 `clk` cycles after the SCK falling edge (or CS falling edge) that causes it.
- `frame_done`, `rx_valid` and `frame_abort` assert 4 cycles after the causing pin edge and last exactly 1 cycle.
- Master constraints:
  - Each SCK high or low phase is at least 4 `clk` periods (SCK ≤ clk/8).
  - CS-fall to first SCK-rise is at least 4 `clk` periods.
  - The master samples MISO on the SCK rising edge.

## Configuration
- `SPI_RESP_RX_EN` defined: the MOSI rx shift register, `rx_data` and `rx_valid` are implemented as described.
- `SPI_RESP_RX_EN` undefined: the rx logic is removed, `rx_data` is tied to 0 and `rx_valid` to 0. All other behaviour is unchanged.

## Test plan
- Load `s_data`=12'hA5C, then run one 16-bit frame at clk/8: MISO reads 16'h0A5C, `frame_done` pulses once, `s_ready` returns to 1, no `underrun`.
- Run a second frame with no new sample: MISO again reads 16'h0A5C and `underrun` pulses once, 4 cycles after CS falls.
- With `SPI_RESP_RX_EN` defined, master sends 16'hC3A1 on MOSI: `rx_data`=16'hC3A1 and `rx_valid` pulses in the same cycle as `frame_done`. Without the macro, `rx_data` stays 0.
- Raise CS after 7 SCK rising edges: `frame_abort` pulses, no `frame_done`, `rx_data` unchanged; the next full frame is correct.
- Present `s_valid` in the same cycle as the frame start with the holding register empty: `underrun` pulses, the old sample is sent, and the next frame sends the new sample.
- Assert `reset` mid-frame with CS held low: all outputs go to their reset values immediately; after reset, no frame starts until CS goes high and falls again; 20 extra SCK pulses after a complete frame keep `miso`=0.
